// File: rtl/wf_7seg_serial_rx.sv
// Receive end of the 4-digit 7-segment serial link: captures 16-bit scan frames into per-digit
// segment registers. Optional glyph decode is built when WF_7SEG_RX_DECODE_EN is defined.
module wf_7seg_serial_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_clk,
  input  logic       ser_dout,
  input  logic       ser_load,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] colon_seg,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_stale,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_ok
);

  // A same-clock source still gets one register stage.
  localparam int unsigned Stages   = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;
  localparam logic [15:0] TimeoutW = 16'(TIMEOUT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;

  logic [Stages-1:0] clk_sync_q, clk_sync_d;
  logic [Stages-1:0] dout_sync_q, dout_sync_d;
  logic [Stages-1:0] load_sync_q, load_sync_d;
  logic [Stages:0]   clk_chain, dout_chain, load_chain;
  logic              clk_s, dout_s, load_s;
  logic              clk_prev_q, load_prev_q;
  logic              clk_rise, load_fall, load_rise;

  logic [1:0]  state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  seg_q [5];
  logic [7:0]  seg_d [5];
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] stale_q, stale_d;
  logic [4:0]  en5;
  logic        en_onehot;
  logic        good;

  always_comb begin
    clk_chain   = {clk_sync_q, ser_clk};
    dout_chain  = {dout_sync_q, ser_dout};
    load_chain  = {load_sync_q, ser_load};
    clk_sync_d  = clk_chain[Stages-1:0];
    dout_sync_d = dout_chain[Stages-1:0];
    load_sync_d = load_chain[Stages-1:0];
  end

  assign clk_s     = clk_sync_q[Stages-1];
  assign dout_s    = dout_sync_q[Stages-1];
  assign load_s    = load_sync_q[Stages-1];
  assign clk_rise  = clk_s & ~clk_prev_q;
  assign load_fall = ~load_s & load_prev_q;
  assign load_rise = load_s & ~load_prev_q;

  // D4 sits in bit 7 of the enable byte; bits 6:4 are pad.
  assign en5       = {sr_q[7], sr_q[3:0]};
  assign en_onehot = (en5 != 5'd0) && ((en5 & (en5 - 5'd1)) == 5'd0);
  assign good      = (cnt_q == 5'd16) && (sr_q[6:4] == 3'b000) && en_onehot;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < 5; i++) seg_d[i] = seg_q[i];
    unique case (state_q)
      StIdle: begin
        if (load_fall) begin
          state_d = StShift;
          sr_d    = '0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (clk_rise) begin
          sr_d = {sr_q[14:0], dout_s};
          if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        end
        if (load_rise) state_d = StCheck;
      end
      StCheck: begin
        state_d = StIdle;
        if (good) begin
          valid_d = 1'b1;
          for (int i = 0; i < 5; i++) begin
            if (en5[i]) seg_d[i] = sr_q[15:8];
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (valid_q) stale_d = '0;
    else if (stale_q != 16'hFFFF) stale_d = stale_q + 16'd1;
    else stale_d = stale_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '0;
      dout_sync_q <= '0;
      load_sync_q <= '1;
      clk_prev_q  <= 1'b0;
      load_prev_q <= 1'b1;
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < 5; i++) seg_q[i] <= 8'hFF;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      stale_q     <= 16'hFFFF;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dout_sync_q <= dout_sync_d;
      load_sync_q <= load_sync_d;
      clk_prev_q  <= clk_s;
      load_prev_q <= load_s;
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < 5; i++) seg_q[i] <= seg_d[i];
      valid_q     <= valid_d;
      err_q       <= err_d;
      stale_q     <= stale_d;
    end
  end

  assign seg0        = seg_q[0];
  assign seg1        = seg_q[1];
  assign seg2        = seg_q[2];
  assign seg3        = seg_q[3];
  assign colon_seg   = seg_q[4];
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign link_stale  = (stale_q >= TimeoutW);

`ifdef WF_7SEG_RX_DECODE_EN
  // Returns {ok, digit}; DP is ignored, and 6/B share a pattern that decodes to 6.
  function automatic logic [4:0] glyph_dec(input logic [6:0] s);
    case (s)
      7'h40:   glyph_dec = {1'b1, 4'h0};
      7'h79:   glyph_dec = {1'b1, 4'h1};
      7'h24:   glyph_dec = {1'b1, 4'h2};
      7'h30:   glyph_dec = {1'b1, 4'h3};
      7'h19:   glyph_dec = {1'b1, 4'h4};
      7'h12:   glyph_dec = {1'b1, 4'h5};
      7'h03:   glyph_dec = {1'b1, 4'h6};
      7'h78:   glyph_dec = {1'b1, 4'h7};
      7'h00:   glyph_dec = {1'b1, 4'h8};
      7'h18:   glyph_dec = {1'b1, 4'h9};
      7'h08:   glyph_dec = {1'b1, 4'hA};
      7'h46:   glyph_dec = {1'b1, 4'hC};
      7'h21:   glyph_dec = {1'b1, 4'hD};
      7'h06:   glyph_dec = {1'b1, 4'hE};
      7'h0E:   glyph_dec = {1'b1, 4'hF};
      default: glyph_dec = {1'b0, 4'hF};
    endcase
  endfunction

  logic [4:0] dec0, dec1, dec2, dec3;
  assign dec0     = glyph_dec(seg_q[0][6:0]);
  assign dec1     = glyph_dec(seg_q[1][6:0]);
  assign dec2     = glyph_dec(seg_q[2][6:0]);
  assign dec3     = glyph_dec(seg_q[3][6:0]);
  assign digit0   = dec0[3:0];
  assign digit1   = dec1[3:0];
  assign digit2   = dec2[3:0];
  assign digit3   = dec3[3:0];
  assign digit_ok = {dec3[4], dec2[4], dec1[4], dec0[4]};
`else
  assign digit0   = 4'h0;
  assign digit1   = 4'h0;
  assign digit2   = 4'h0;
  assign digit3   = 4'h0;
  assign digit_ok = 4'h0;
`endif

endmodule
